// File: rtl/mmio_arbiter_pkg.sv
// Shared MMIO arbiter definitions: bus widths, channel FSM states, host
// select type and the round-robin pick helper.
package mmio_arbiter_pkg;

    localparam int unsigned HOST_COUNT   = 4;
    localparam int unsigned MMIO_INDEX_W = 16;
    localparam int unsigned MMIO_DATA_W  = 32;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    typedef logic [1:0] host_sel_t;

    // First requesting host after 'last', scanning first..fourth and wrapping.
    function automatic host_sel_t rr_pick(input logic [HOST_COUNT-1:0] req,
                                          input host_sel_t last);
        host_sel_t pick;
        host_sel_t cand;
        logic      found;
        pick  = last;
        found = 1'b0;
        for (int unsigned off = 1; off <= HOST_COUNT; off++) begin
            cand = host_sel_t'(last + off);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mmio_if.sv
// MMIO bundle: independent read and write request/ack channels.
interface mmio_if;
    import mmio_arbiter_pkg::*;

    logic                    read_req;
    logic [MMIO_INDEX_W-1:0] read_index;
    logic                    read_ack;
    logic [MMIO_DATA_W-1:0]  read_data;
    logic                    write_req;
    logic [MMIO_INDEX_W-1:0] write_index;
    logic [MMIO_DATA_W-1:0]  write_data;
    logic                    write_ack;

    modport device (
        input  read_req, read_index, write_req, write_index, write_data,
        output read_ack, read_data, write_ack
    );

    modport host (
        output read_req, read_index, write_req, write_index, write_data,
        input  read_ack, read_data, write_ack
    );

endinterface

// File: rtl/mmio_arbiter_channel.sv
// One arbitration channel: IDLE/BUSY FSM with round-robin grant.
// Optional BUSY-cycle timeout under TIA_MMIO_ARBITER_TIMEOUT_EN.
module mmio_arbiter_channel
    import mmio_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [HOST_COUNT-1:0] host_req,
    input  logic                  dev_ack,
    output logic                  dev_req,
    output host_sel_t             grant,
    output logic [HOST_COUNT-1:0] host_ack
`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
    ,
    output logic                  timeout_error
`endif
);

    arb_state_t state, next_state;
    host_sel_t  grant_q, next_grant;
    host_sel_t  last_q, next_last;

`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, next_count;
    logic             err_q, next_err;
`endif

    // State, grant and last-grant registers; reset leaves fourth as last so first wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            last_q  <= host_sel_t'(HOST_COUNT - 1);
`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
            count_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            grant_q <= next_grant;
            last_q  <= next_last;
`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
            count_q <= next_count;
            err_q   <= next_err;
`endif
        end
    end

    // Next-state and pass-through control; a dropped req abandons the grant.
    always_comb begin
        next_state = state;
        next_grant = grant_q;
        next_last  = last_q;
        dev_req    = 1'b0;
        host_ack   = '0;
`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
        next_count = count_q;
        next_err   = err_q;
`endif
        case (state)
            IDLE: begin
`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
                next_count = '0;
`endif
                if (|host_req) begin
                    next_grant = rr_pick(host_req, last_q);
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (!host_req[grant_q]) begin
                    next_state = IDLE;
                end else begin
                    dev_req = 1'b1;
                    if (dev_ack) begin
                        host_ack[grant_q] = 1'b1;
                        next_last         = grant_q;
                        next_state        = IDLE;
                    end
`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
                    else if (count_q == CNT_LAST) begin
                        host_ack[grant_q] = 1'b1;
                        next_last         = grant_q;
                        next_err          = 1'b1;
                        next_state        = IDLE;
                    end else begin
                        next_count = count_q + CNT_W'(1);
                    end
`endif
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign grant = grant_q;

`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
    assign timeout_error = err_q;
`endif

endmodule

// File: rtl/four_way_mmio_arbiter.sv
// Four-host MMIO arbiter onto one shared device; reads and writes are
// arbitrated independently. Optional ack timeout under TIA_MMIO_ARBITER_TIMEOUT_EN.
module four_way_mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic   clock,
    input  logic   reset,
    mmio_if.device first_host_interface,
    mmio_if.device second_host_interface,
    mmio_if.device third_host_interface,
    mmio_if.device fourth_host_interface,
    mmio_if.host   device_interface
`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
    ,
    output logic   timeout_error
`endif
);

    logic [HOST_COUNT-1:0]   rd_req, wr_req, rd_ack, wr_ack;
    logic [MMIO_INDEX_W-1:0] rd_index [HOST_COUNT];
    logic [MMIO_INDEX_W-1:0] wr_index [HOST_COUNT];
    logic [MMIO_DATA_W-1:0]  wr_data  [HOST_COUNT];
    logic [MMIO_DATA_W-1:0]  rd_ret;
    host_sel_t               rd_grant, wr_grant;
    logic                    rd_dev_req, wr_dev_req;

    assign rd_req = {fourth_host_interface.read_req,  third_host_interface.read_req,
                     second_host_interface.read_req,  first_host_interface.read_req};
    assign wr_req = {fourth_host_interface.write_req, third_host_interface.write_req,
                     second_host_interface.write_req, first_host_interface.write_req};

    assign rd_index[0] = first_host_interface.read_index;
    assign rd_index[1] = second_host_interface.read_index;
    assign rd_index[2] = third_host_interface.read_index;
    assign rd_index[3] = fourth_host_interface.read_index;
    assign wr_index[0] = first_host_interface.write_index;
    assign wr_index[1] = second_host_interface.write_index;
    assign wr_index[2] = third_host_interface.write_index;
    assign wr_index[3] = fourth_host_interface.write_index;
    assign wr_data[0]  = first_host_interface.write_data;
    assign wr_data[1]  = second_host_interface.write_data;
    assign wr_data[2]  = third_host_interface.write_data;
    assign wr_data[3]  = fourth_host_interface.write_data;

`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
    logic rd_timeout, wr_timeout;
    assign timeout_error = rd_timeout | wr_timeout;
`endif

    mmio_arbiter_channel #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_read_channel (
        .clock         (clock),
        .reset         (reset),
        .host_req      (rd_req),
        .dev_ack       (device_interface.read_ack),
        .dev_req       (rd_dev_req),
        .grant         (rd_grant),
        .host_ack      (rd_ack)
`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
        ,
        .timeout_error (rd_timeout)
`endif
    );

    mmio_arbiter_channel #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_write_channel (
        .clock         (clock),
        .reset         (reset),
        .host_req      (wr_req),
        .dev_ack       (device_interface.write_ack),
        .dev_req       (wr_dev_req),
        .grant         (wr_grant),
        .host_ack      (wr_ack)
`ifdef TIA_MMIO_ARBITER_TIMEOUT_EN
        ,
        .timeout_error (wr_timeout)
`endif
    );

    assign device_interface.read_req    = rd_dev_req;
    assign device_interface.read_index  = rd_dev_req ? rd_index[rd_grant] : '0;
    assign device_interface.write_req   = wr_dev_req;
    assign device_interface.write_index = wr_dev_req ? wr_index[wr_grant] : '0;
    assign device_interface.write_data  = wr_dev_req ? wr_data[wr_grant] : '0;

    // Read data only rides a real device ack, so a timeout ack returns zero.
    assign rd_ret = device_interface.read_ack ? device_interface.read_data : '0;

    assign first_host_interface.read_ack   = rd_ack[0];
    assign second_host_interface.read_ack  = rd_ack[1];
    assign third_host_interface.read_ack   = rd_ack[2];
    assign fourth_host_interface.read_ack  = rd_ack[3];
    assign first_host_interface.read_data  = rd_ack[0] ? rd_ret : '0;
    assign second_host_interface.read_data = rd_ack[1] ? rd_ret : '0;
    assign third_host_interface.read_data  = rd_ack[2] ? rd_ret : '0;
    assign fourth_host_interface.read_data = rd_ack[3] ? rd_ret : '0;
    assign first_host_interface.write_ack  = wr_ack[0];
    assign second_host_interface.write_ack = wr_ack[1];
    assign third_host_interface.write_ack  = wr_ack[2];
    assign fourth_host_interface.write_ack = wr_ack[3];

endmodule
